// File: rtl/affine_mul_arbiter.sv
// affine_mul_arbiter: round-robin owner selection for one shared multi-cycle signed multiplier,
// with registered product return, per-owner done pulse and a watchdog abort on hung operations.
module affine_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   a_i,
    input  logic [NREQ*WIDTH-1:0]   b_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [NREQ-1:0]         done_o,
    output logic                    err_o,
    output logic [2*WIDTH-1:0]      result_o,
    output logic [15:0]             ops_count_o,
    output logic                    mul_start_o,
    output logic [WIDTH-1:0]        mul_a_o,
    output logic [WIDTH-1:0]        mul_b_o,
    input  logic [2*WIDTH-1:0]      mul_result_i,
    input  logic                    mul_busy_i
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick;
    logic            found;
    logic [CW-1:0]   wd;
    logic            err;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic            active;

    // first requester at or after ptr, wrapping
    always_comb begin
        int idx;
        idx   = 0;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign active      = (state == ARM) || (state == WAIT);
    assign gnt_o       = (state == IDLE) ? '0 : NREQ'(1) << owner;
    assign done_o      = (state == DONE) ? NREQ'(1) << owner : '0;
    assign err_o       = (state == DONE) && err;
    assign mul_start_o = state == ISSUE;
    // operands pass straight through while issuing, then come from the copy taken then
    assign mul_a_o     = (state == ISSUE) ? a_i[owner*WIDTH +: WIDTH] : active ? a_q : '0;
    assign mul_b_o     = (state == ISSUE) ? b_i[owner*WIDTH +: WIDTH] : active ? b_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= '0;
            wd          <= '0;
            err         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_o    <= '0;
            ops_count_o <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    owner <= pick;
                    state <= ISSUE;
                end
                ISSUE: begin
                    a_q   <= a_i[owner*WIDTH +: WIDTH];
                    b_q   <= b_i[owner*WIDTH +: WIDTH];
                    state <= ARM;
                end
                ARM: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: if (!mul_busy_i) begin
                    result_o <= mul_result_i;
                    err      <= 1'b0;
                    state    <= DONE;
                end else if (wd == CW'(TIMEOUT - 1)) begin
                    result_o <= '0;
                    err      <= 1'b1;
                    state    <= DONE;
                end else begin
                    wd <= wd + 1'b1;
                end
                DONE: begin
                    ops_count_o <= ops_count_o + 16'd1;
                    ptr         <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
